// File: rtl/m_gate_checker_if.sv
// rtl/m_gate_checker_if.sv - Stimulus/response and result bundle of the gate checker.
interface m_gate_checker_if;
    logic       start;
    logic       func_sel;
    logic       dut_out;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;
    logic [7:0] fail_vec;

    modport master (
        output start, func_sel, dut_out,
        input  in1, in2, in3, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        input  start, func_sel, dut_out,
        output in1, in2, in3, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/m_gate_checker.sv
// rtl/m_gate_checker.sv - Exhaustive 3-input AND/XOR gate checker with per-vector fail map.
module m_gate_checker #(
    parameter int unsigned SETTLE = 2
) (
    input logic        clk,
    input logic        rst_n,
    m_gate_checker_if.slave bus
);

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [2:0] vec_idx, vec_nxt;
    logic [3:0] settle_cnt, settle_nxt;
    logic       func_q, func_nxt;
    logic [3:0] err_q, err_nxt;
    logic [7:0] fail_q, fail_nxt;
    logic       done_q, done_nxt;
    logic       expected;
    logic       sample_edge;

    // settle_cnt holds the 1-based cycle number of the vector currently applied
    assign expected    = func_q ? (^vec_idx) : (&vec_idx);
    assign sample_edge = (state == RUN) && (settle_cnt == SETTLE_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec_idx    <= '0;
            settle_cnt <= '0;
            func_q     <= 1'b0;
            err_q      <= '0;
            fail_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            vec_idx    <= vec_nxt;
            settle_cnt <= settle_nxt;
            func_q     <= func_nxt;
            err_q      <= err_nxt;
            fail_q     <= fail_nxt;
            done_q     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        vec_nxt    = vec_idx;
        settle_nxt = settle_cnt;
        func_nxt   = func_q;
        err_nxt    = err_q;
        fail_nxt   = fail_q;
        done_nxt   = done_q;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt  = RUN;
                    func_nxt   = bus.func_sel;
                    err_nxt    = '0;
                    fail_nxt   = '0;
                    done_nxt   = 1'b0;
                    vec_nxt    = '0;
                    settle_nxt = 4'd1;
                end
            end
            RUN: begin
                if (sample_edge) begin
                    if (bus.dut_out != expected) begin
                        if (err_q != 4'd8) begin
                            err_nxt = err_q + 4'd1;
                        end
                        fail_nxt[vec_idx] = 1'b1;
                    end
                    // start is deliberately not looked at here, so a start on the final edge is dropped
                    if (vec_idx == 3'd7) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        vec_nxt    = vec_idx + 3'd1;
                        settle_nxt = 4'd1;
                    end
                end else begin
                    settle_nxt = settle_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in1      = vec_idx[2];
    assign bus.in2      = vec_idx[1];
    assign bus.in3      = vec_idx[0];
    assign bus.busy     = (state == RUN);
    assign bus.done     = done_q;
    assign bus.pass     = done_q && (err_q == 4'd0);
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_m_gate_checker.sv
// tb/tb_m_gate_checker.sv - Scoreboard bench: random gate tables against a truth-table reference.
module tb_m_gate_checker;

    localparam int S      = 2;
    localparam int S_SLOW = 4;

    typedef struct {
        logic [7:0] fv;
        int         ec;
        bit         nonzero;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    m_gate_checker_if bus();
    m_gate_checker_if sbus();

    m_gate_checker #(.SETTLE(S)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    m_gate_checker #(.SETTLE(S_SLOW)) u_slow (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    // Gate network under test: a truth table, or an AND gate behind three flops
    logic [7:0] tt         = 8'h00;
    bit         delay_mode = 1'b0;
    logic [2:0] d_main     = 3'b000;
    logic [2:0] d_slow     = 3'b000;

    always @(posedge clk) begin
        d_main <= {d_main[1:0], bus.in1 & bus.in2 & bus.in3};
        d_slow <= {d_slow[1:0], sbus.in1 & sbus.in2 & sbus.in3};
    end

    assign bus.dut_out  = delay_mode ? d_main[2] : tt[{bus.in1, bus.in2, bus.in3}];
    assign sbus.dut_out = d_slow[2];

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] ref_table(input bit f);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) begin
            int a, b, c;
            a = (k / 4) % 2;
            b = (k / 2) % 2;
            c = k % 2;
            r[k] = f ? (((a + b + c) % 2) == 1) : ((a * b * c) == 1);
        end
        return r;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic issue(input bit f, input logic [7:0] t, input bit nz);
        exp_t e;
        logic [7:0] fv;
        tt           = t;
        bus.func_sel = f;
        fv           = t ^ ref_table(f);
        e.fv         = fv;
        e.ec         = $countones(fv);
        e.nonzero    = nz;
        sb.push_back(e);
        pulse_start();
        chk("accept_err_clear", bus.err_cnt, 0);
        chk("accept_fv_clear", bus.fail_vec, 0);
        chk("accept_done_clear", bus.done, 0);
        chk("accept_busy", bus.busy, 1);
        bus.func_sel = 1'($urandom);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        if (i == 200) chk("done_timeout", 0, 1);
        else chk("hold_vec7", {bus.in1, bus.in2, bus.in3}, 7);
    endtask

    task automatic run(input bit f, input logic [7:0] t);
        issue(f, t, 1'b0);
        wait_done();
    endtask

    initial begin : monitor
        int   busy_cyc;
        logic done_prev;
        exp_t e;
        busy_cyc  = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cyc  = 0;
                done_prev = 1'b0;
            end else begin
                if (bus.busy) begin
                    busy_cyc++;
                    chk("vector", {bus.in1, bus.in2, bus.in3}, (busy_cyc - 1) / S);
                    chk("pass_while_busy", bus.pass, 0);
                end
                if (bus.done && !done_prev) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("run_cycles", busy_cyc, 8 * S);
                        if (e.nonzero) begin
                            chk("err_nonzero", bus.err_cnt != 0, 1);
                            chk("pass_delay", bus.pass, 0);
                        end else begin
                            chk("err_cnt", bus.err_cnt, e.ec);
                            chk("fail_vec", bus.fail_vec, e.fv);
                            chk("pass", bus.pass, e.ec == 0);
                        end
                    end
                    busy_cyc = 0;
                end
                done_prev = bus.done;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1);
    end

    initial begin : stimulus
        bus.start     = 1'b0;
        bus.func_sel  = 1'b0;
        sbus.start    = 1'b0;
        sbus.func_sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in", {bus.in1, bus.in2, bus.in3}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_err", bus.err_cnt, 0);
        chk("rst_fv", bus.fail_vec, 0);
        rst_n = 1'b1;

        run(1'b0, ref_table(1'b0));
        run(1'b1, ref_table(1'b1));
        run(1'b0, ref_table(1'b1));
        run(1'b0, 8'hFF);
        run(1'b1, 8'h00);

        for (int r = 0; r < 20; r++) begin
            bit         f;
            logic [7:0] t;
            f = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       t = ref_table(f);
                1:       t = ref_table(f) ^ (8'h01 << $urandom_range(0, 7));
                2:       t = 8'($urandom);
                default: t = ~ref_table(f);
            endcase
            run(f, t);
        end

        // Slow gate network: too fast a checker sees stale responses
        delay_mode = 1'b1;
        issue(1'b0, 8'h00, 1'b1);
        wait_done();
        delay_mode = 1'b0;

        @(negedge clk);
        sbus.start = 1'b1;
        @(negedge clk);
        sbus.start = 1'b0;
        begin
            int i;
            for (i = 0; i < 200; i++) begin
                @(negedge clk);
                if (sbus.done) break;
            end
            if (i == 200) chk("slow_timeout", 0, 1);
            else begin
                chk("slow_pass", sbus.pass, 1);
                chk("slow_err", sbus.err_cnt, 0);
                chk("slow_fv", sbus.fail_vec, 0);
            end
        end

        // start on the vector-7 sampling edge completes without restarting
        issue(1'b1, ref_table(1'b1), 1'b0);
        repeat (8 * S - 1) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("coinc_done", bus.done, 1);
        chk("coinc_busy", bus.busy, 0);
        @(negedge clk);
        chk("coinc_no_restart", bus.busy, 0);
        chk("coinc_pass", bus.pass, 1);

        // Async reset during vector 4 of a faulty run
        tt           = ref_table(1'b0) ^ 8'h01;
        bus.func_sel = 1'b0;
        pulse_start();
        repeat (4 * S) @(negedge clk);
        chk("pre_rst_vec4", {bus.in1, bus.in2, bus.in3}, 4);
        chk("pre_rst_err", bus.err_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in", {bus.in1, bus.in2, bus.in3}, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_pass", bus.pass, 0);
        chk("arst_err", bus.err_cnt, 0);
        chk("arst_fv", bus.fail_vec, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", bus.busy, 0);

        // Fresh faulty run with a mid-run start, then restart from DONE
        issue(1'b0, ref_table(1'b0) ^ 8'h24, 1'b0);
        repeat (5) @(negedge clk);
        bus.func_sel = 1'b1;
        pulse_start();
        wait_done();
        chk("midrun_err", bus.err_cnt, 2);
        run(1'b0, ref_table(1'b0));
        chk("restart_err_cleared", bus.err_cnt, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
